multicycle_sequencer: RTL and testbench

//  Multicycle FSM that sequences the single shared datapath (PC, instruction register, ALU,

---
 rtl/multicycle_sequencer_pkg.sv | 17 +
 rtl/multicycle_sequencer_if.sv | 39 +++
 rtl/multicycle_sequencer_link_register.sv | 57 +++++
 rtl/multicycle_sequencer.sv | 124 ++++++++++++
 tb/tb_multicycle_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_sequencer_pkg.sv
// Shared types for the multicycle sequencer: FSM state encoding
// and default address geometry for the LL/SC link register.
package multicycle_sequencer_pkg;

   localparam int ADDR_W_DEF   = 32;
   localparam int OFFSET_W_DEF = 2;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } mc_state_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath/cache bundle. The master side is the
// sequencer; the slave side is the datapath, caches and decoder.
interface multicycle_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              RegWen;
   logic              mem2reg;
   logic              MemWrite;
   logic              atomic;
   logic              halt;
   logic              ihit;
   logic              dhit;
   logic [ADDR_W-1:0] daddr;
   logic              snp_inv;
   logic [ADDR_W-1:0] snp_addr;
   logic              iREN;
   logic              dREN;
   logic              dWEN;
   logic              ir_en;
   logic              pc_en;
   logic              reg_wen;
   logic              sc_result;
   logic              halted;
   logic [2:0]        state;

   modport master (
      input  RegWen, mem2reg, MemWrite, atomic, halt,
      input  ihit, dhit, daddr, snp_inv, snp_addr,
      output iREN, dREN, dWEN, ir_en, pc_en, reg_wen,
      output sc_result, halted, state
   );

   modport slave (
      output RegWen, mem2reg, MemWrite, atomic, halt,
      output ihit, dhit, daddr, snp_inv, snp_addr,
      input  iREN, dREN, dWEN, ir_en, pc_en, reg_wen,
      input  sc_result, halted, state
   );
endinterface

// File: rtl/multicycle_sequencer_link_register.sv
// LL/SC link register: word-granular address compare, set on LL,
// cleared by a store to the linked word or a matching snoop.
module multicycle_sequencer_link_register #(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              set_i,
   input  logic              st_clr_i,
   input  logic              snoop_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [ADDR_W-1:0] snp_addr_i,
   output logic              match_o,
   output logic              snp_cur_o
);
   localparam int HI = ADDR_W - 1;

   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              snp_link;
   logic              st_link;
   logic              unused_snp_lo;

   assign snp_link = snoop_i &&
      (snp_addr_i[HI:OFFSET_W] == addr_q[HI:OFFSET_W]);
   assign st_link = st_clr_i &&
      (addr_i[HI:OFFSET_W] == addr_q[HI:OFFSET_W]);
   assign match_o = valid_q &&
      (addr_i[HI:OFFSET_W] == addr_q[HI:OFFSET_W]);
   assign snp_cur_o = snoop_i &&
      (snp_addr_i[HI:OFFSET_W] == addr_i[HI:OFFSET_W]);
   assign unused_snp_lo = ^snp_addr_i[OFFSET_W-1:0];

   // A snoop landing with the LL fill is ordered before it.
   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      if (set_i) begin
         valid_d = 1'b1;
         addr_d  = addr_i;
      end else if (st_link || snp_link) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the shared datapath: fetch, decode,
// execute, memory and write-back strobes, plus LL/SC resolution.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int OFFSET_W = OFFSET_W_DEF
) (
   input logic                    CLK,
   input logic                    RST,
   multicycle_sequencer_if.master io
);
   mc_state_t state_q, state_d;
   logic      sc_q, sc_d;
   logic      halted_q, halted_d;

   logic iren, dren, dwen, ir, pc, regw;
   logic ll_set, st_clr;
   logic link_match, snp_cur;
   logic is_mem, is_sc, is_ll, sc_ok;

   assign is_mem = io.mem2reg | io.MemWrite;
   assign is_sc  = io.atomic & io.MemWrite;
   assign is_ll  = io.atomic & io.mem2reg;
   assign sc_ok  = link_match & ~snp_cur;

   multicycle_sequencer_link_register #(
      .ADDR_W   (ADDR_W),
      .OFFSET_W (OFFSET_W)
   ) u_link (
      .clk_i      (CLK),
      .rst_i      (RST),
      .set_i      (ll_set),
      .st_clr_i   (st_clr),
      .snoop_i    (io.snp_inv),
      .addr_i     (io.daddr),
      .snp_addr_i (io.snp_addr),
      .match_o    (link_match),
      .snp_cur_o  (snp_cur)
   );

   always_comb begin
      state_d  = state_q;
      sc_d     = sc_q;
      halted_d = halted_q;
      iren     = 1'b0;
      dren     = 1'b0;
      dwen     = 1'b0;
      ir       = 1'b0;
      pc       = 1'b0;
      regw     = 1'b0;
      ll_set   = 1'b0;
      st_clr   = 1'b0;
      unique case (state_q)
         FETCH: begin
            iren = 1'b1;
            if (io.ihit) begin
               ir      = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (io.halt) begin
               state_d  = HALT;
               halted_d = 1'b1;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (is_sc) begin
               sc_d    = sc_ok;
               state_d = sc_ok ? MEM : WB;
            end else begin
               state_d = is_mem ? MEM : WB;
            end
         end
         MEM: begin
            dren = io.mem2reg & ~io.MemWrite;
            dwen = io.MemWrite;
            if (io.dhit) begin
               state_d = WB;
               ll_set  = is_ll;
               st_clr  = io.MemWrite;
            end
         end
         WB: begin
            pc      = 1'b1;
            regw    = io.RegWen;
            state_d = FETCH;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= FETCH;
         sc_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sc_q     <= sc_d;
         halted_q <= halted_d;
      end
   end

   // Reset drops any in-flight cache request in the same cycle.
   assign io.iREN      = iren & ~RST;
   assign io.dREN      = dren & ~RST;
   assign io.dWEN      = dwen & ~RST;
   assign io.ir_en     = ir & ~RST;
   assign io.pc_en     = pc & ~RST;
   assign io.reg_wen   = regw & ~RST;
   assign io.sc_result = sc_q;
   assign io.halted    = halted_q;
   assign io.state     = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: an instruction-level model predicts per-instruction
// strobe counts and LL/SC outcome; a monitor checks at each WB.
module tb_multicycle_sequencer;
   import multicycle_sequencer_pkg::*;

   localparam int AW = 32;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   multicycle_sequencer_if #(.ADDR_W(AW)) bus ();

   multicycle_sequencer #(
      .ADDR_W   (AW),
      .OFFSET_W (2)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .io  (bus)
   );

   always #5 CLK = ~CLK;

   typedef enum int {K_ALU, K_NOP, K_LW, K_SW, K_LL, K_SC} kind_t;

   typedef struct {
      int cycles;
      int iren;
      int dren;
      int dwen;
      bit regw;
      bit scr;
   } exp_t;

   exp_t expq[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   bit   mon_en = 1'b0;

   bit          m_lv = 1'b0;
   logic [31:0] m_la = '0;
   bit          m_sc = 1'b0;

   int m_cyc, m_ir, m_irn, m_dr, m_dw, m_both;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp_v);
      tests++;
      if (act !== exp_v) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   function automatic bit weq(logic [31:0] a, logic [31:0] b);
      return a[31:2] == b[31:2];
   endfunction

   function automatic void snoop_model(logic [31:0] sa);
      if (m_lv && weq(sa, m_la)) m_lv = 1'b0;
   endfunction

   always @(negedge CLK) begin
      if (!mon_en) begin
         m_cyc = 0; m_ir = 0; m_irn = 0;
         m_dr = 0; m_dw = 0; m_both = 0;
      end else begin
         m_cyc++;
         if (bus.iREN) m_ir++;
         if (bus.ir_en) m_irn++;
         if (bus.dREN) m_dr++;
         if (bus.dWEN) m_dw++;
         if (bus.dREN && bus.dWEN) m_both++;
         if (bus.pc_en) begin
            if (expq.size() == 0) begin
               check("unexpected_wb", 1, 0);
            end else begin
               mon_e = expq.pop_front();
               check("latency", m_cyc, mon_e.cycles);
               check("iren_cycles", m_ir, mon_e.iren);
               check("ir_en_pulses", m_irn, 1);
               check("dren_cycles", m_dr, mon_e.dren);
               check("dwen_cycles", m_dw, mon_e.dwen);
               check("dren_dwen_overlap", m_both, 0);
               check("reg_wen", 32'(bus.reg_wen), 32'(mon_e.regw));
               check("sc_result", 32'(bus.sc_result), 32'(mon_e.scr));
            end
            m_cyc = 0; m_ir = 0; m_irn = 0;
            m_dr = 0; m_dw = 0; m_both = 0;
         end else if (m_cyc > 300) begin
            check("wb_timeout", m_cyc, 0);
            m_cyc = 0;
         end
      end
   end

   // Call at posedge+1 of the instruction's first FETCH cycle.
   task automatic run_instr(input kind_t k, input logic [31:0] a,
                            input int fw, input int dw,
                            input int s, input logic [31:0] sa);
      int   exec_c, mem_last, n;
      bit   mem, ok, st, ld;
      exp_t e;
      st = (k == K_SW) || (k == K_SC);
      ld = (k == K_LW) || (k == K_LL);
      exec_c = fw + 2;
      if (s >= 0 && s <= exec_c) snoop_model(sa);
      if (k == K_SC) begin
         ok   = m_lv && weq(a, m_la);
         m_sc = ok;
         mem  = ok;
      end else begin
         mem = ld || (k == K_SW);
      end
      mem_last = mem ? exec_c + 1 + dw : exec_c;
      n = mem_last + 2;
      if (s > exec_c && s <= mem_last) snoop_model(sa);
      if (mem && k == K_LL) begin
         m_lv = 1'b1;
         m_la = a;
      end else if (mem && st && weq(a, m_la)) begin
         m_lv = 1'b0;
      end
      if (s == n - 1) snoop_model(sa);
      e.cycles = n;
      e.iren   = fw + 1;
      e.dren   = (mem && ld) ? dw + 1 : 0;
      e.dwen   = (mem && st) ? dw + 1 : 0;
      e.regw   = (k == K_ALU) || ld || (k == K_SC);
      e.scr    = m_sc;
      expq.push_back(e);
      bus.RegWen   = e.regw;
      bus.mem2reg  = ld;
      bus.MemWrite = st;
      bus.atomic   = (k == K_LL) || (k == K_SC);
      bus.halt     = 1'b0;
      bus.daddr    = a;
      bus.snp_addr = sa;
      for (int c = 0; c < n; c++) begin
         bus.ihit    = (c == fw);
         bus.dhit    = mem && (c == mem_last);
         bus.snp_inv = (c == s);
         @(posedge CLK); #1;
      end
      bus.ihit    = 1'b0;
      bus.dhit    = 1'b0;
      bus.snp_inv = 1'b0;
   endtask

   logic [31:0] addrs [4];
   int          bad;

   initial begin
      addrs = '{32'h100, 32'h101, 32'h104, 32'h200};
      bus.RegWen = 0; bus.mem2reg = 0; bus.MemWrite = 0;
      bus.atomic = 0; bus.halt = 0; bus.ihit = 0; bus.dhit = 0;
      bus.daddr = '0; bus.snp_inv = 0; bus.snp_addr = '0;

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_state", 32'(bus.state), 0);
      check("rst_iren", 32'(bus.iREN), 0);
      check("rst_pc_en", 32'(bus.pc_en), 0);
      check("rst_halted", 32'(bus.halted), 0);
      check("rst_sc_result", 32'(bus.sc_result), 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      mon_en = 1'b1;

      run_instr(K_ALU, 32'h0, 2, 0, -1, 32'h0);
      run_instr(K_LW, 32'h40, 0, 3, -1, 32'h0);
      run_instr(K_LL, 32'h100, 1, 1, -1, 32'h0);
      run_instr(K_SC, 32'h100, 0, 0, -1, 32'h0);
      run_instr(K_SC, 32'h100, 0, 0, -1, 32'h0);
      run_instr(K_LL, 32'h100, 0, 0, -1, 32'h0);
      run_instr(K_ALU, 32'h0, 1, 0, 0, 32'h104);
      run_instr(K_ALU, 32'h0, 1, 0, 0, 32'h100);
      run_instr(K_SC, 32'h100, 0, 0, -1, 32'h0);
      run_instr(K_LL, 32'h100, 0, 0, -1, 32'h0);
      run_instr(K_SC, 32'h100, 1, 0, 3, 32'h100);
      run_instr(K_LL, 32'h200, 0, 1, 4, 32'h200);
      run_instr(K_SC, 32'h200, 0, 2, -1, 32'h0);
      run_instr(K_LL, 32'h100, 0, 0, -1, 32'h0);
      run_instr(K_SC, 32'h101, 0, 0, -1, 32'h0);
      run_instr(K_LL, 32'h100, 0, 0, -1, 32'h0);
      run_instr(K_SW, 32'h102, 0, 1, -1, 32'h0);
      run_instr(K_SC, 32'h100, 0, 0, -1, 32'h0);

      for (int i = 0; i < 60; i++) begin
         run_instr(kind_t'($urandom_range(0, 5)),
                   addrs[$urandom_range(0, 3)],
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   ($urandom_range(0, 2) == 0) ?
                      int'($urandom_range(0, 9)) : -1,
                   addrs[$urandom_range(0, 3)]);
      end

      run_instr(K_LL, 32'h100, 0, 0, -1, 32'h0);
      mon_en = 1'b0;
      bus.RegWen = 1; bus.mem2reg = 1; bus.MemWrite = 0;
      bus.atomic = 0; bus.daddr = 32'h100;
      bus.ihit = 1;
      @(posedge CLK); #1;
      bus.ihit = 0;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      @(negedge CLK);
      check("mem_dren_before_rst", 32'(bus.dREN), 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      check("rst_drops_dren", 32'(bus.dREN), 0);
      check("rst_dwen_low", 32'(bus.dWEN), 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      bus.mem2reg = 0;
      @(negedge CLK);
      check("post_rst_state", 32'(bus.state), 0);
      check("post_rst_iren", 32'(bus.iREN), 1);
      m_lv = 1'b0; m_la = '0; m_sc = 1'b0;
      expq.delete();
      @(posedge CLK); #1;
      mon_en = 1'b1;
      run_instr(K_SC, 32'h100, 0, 0, -1, 32'h0);
      mon_en = 1'b0;

      bus.RegWen = 0; bus.mem2reg = 0; bus.MemWrite = 0;
      bus.atomic = 0; bus.halt = 1; bus.ihit = 1;
      @(posedge CLK); #1;
      bus.ihit = 0;
      @(posedge CLK); #1;
      bus.halt = 0;
      @(negedge CLK);
      check("halt_state", 32'(bus.state), 32'(HALT));
      check("halted", 32'(bus.halted), 1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (bus.iREN || bus.pc_en || bus.ir_en ||
             bus.reg_wen || bus.dREN || bus.dWEN ||
             !bus.halted)
            bad++;
      end
      check("halt_absorbing", bad, 0);

      check("queue_drained", expq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
